nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that time-shares one external 4-bit ripple-carry adder slice to perform a 4*NIBBLES-bit add or subtract, one nibble per cycle, LSB nibble first.
- Drives the slice's A/B/Cin, captures its S/Cout, chains the carry through a register, and reports the result with a start/ready/done handshake.
- Sits between operand registers and the shared 4-bit adder in the datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a new operation; sampled only when ready=1.
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
- cin  input  1  carry-in for add mode; ignored in sub mode.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- ready  output  1  controller can accept start.
- done  output  1  one-cycle pulse; result valid.
- result  output  W  sum/difference; held until the next accepted start.
- cout_o  output  1  final carry out (sub mode: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- add_a  output  4  nibble to adder slice A.
- add_b  output  4  nibble to adder slice B (already inverted in sub mode).
- add_cin  output  1  carry to adder slice.
- add_s  input  4  adder slice sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  adder slice carry out.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; result=0, cout_o=0, ovf=0, done=0, ready=1.
  - An operation in progress is aborted and no done is issued.
  - add_a/add_b/add_cin = 0.
- States:
  - IDLE: ready=1.
  - RUN: ready=0; nibble index k counts 0..NIBBLES-1.
  - DONE: ready=1, done=1 for exactly one cycle.
- Accept: rising edge with ready=1 and start=1.
  - Latch op_a, and op_b XOR {W{sub}}.
  - Carry register = sub ? 1 : cin.
  - k=0; go to RUN.
- RUN, cycle k:
  - add_a = A[4k+3:4k]; add_b = B_eff[4k+3:4k]; add_cin = carry register.
  - At the edge: result[4k+3:4k] <= add_s; carry <= add_cout.
  - If k=NIBBLES-1: cout_o <= add_cout; ovf <= (A[W-1]==B_eff[W-1]) && (add_s[3]!=A[W-1]); go to DONE.
  - Otherwise k <= k+1.
- Latency: start edge at cycle 0; RUN during cycles 1..NIBBLES; done high in cycle NIBBLES+1.
- DONE: go to IDLE, or directly back to RUN if start=1 (back-to-back; done still pulses this cycle).
- Outside RUN: add_a/add_b/add_cin are driven 0.
- start while ready=0 is ignored; it is not queued.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- result/cout_o/ovf remain stable from DONE until overwritten by the next operation. Partial nibbles are written during RUN.
- The slice is assumed to compute add_s/add_cout combinationally in the same cycle; no wait states.
- Arithmetic: all modulo 2^W; no saturation.

Test Plan:
- NIBBLES=4, add, cin=0, 0x1234+0x4321 -> result 0x5555, cout_o 0, ovf 0.
  - done in cycle 5 after the start edge; ready low cycles 1-4.
  - add_a sequence 4,3,2,1.
- add 0xFFFF+0x0001, cin=0 -> result 0x0000, cout_o 1, ovf 0.
  - add_cin sequence 0,1,1,1.
- add 0x7FFF+0x0001 -> 0x8000, ovf 1, cout_o 0.
- sub 0x0005-0x0007 -> 0xFFFE, cout_o 0, ovf 0.
- sub 0x8000-0x0001 -> 0x7FFF, ovf 1, cout_o 1.
  - First add_b=0xE, add_cin=1.
- start pulsed in cycle 2 of a run -> ignored; first result unchanged, single done.
  - start held high in the DONE cycle -> second op (0x0001+0x0001) done 0x0002 exactly 5 cycles later.
- rst asserted mid-RUN (cycle 3) -> ready=1, result=0, done never pulses.
  - The next op after release completes normally.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle between the nibble-serial add controller, its requester,
// and the shared 4-bit adder slice.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         cout_o;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport master (
        output start, sub, cin, op_a, op_b,
        output add_s, add_cout,
        input  ready, done, result, cout_o, ovf,
        input  add_a, add_b, add_cin
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        input  add_s, add_cout,
        output ready, done, result, cout_o, ovf,
        output add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences one shared 4-bit adder slice over NIBBLES nibbles,
// LSB first, to form a W-bit add or subtract.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q;
    logic [KW-1:0]  k_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   result_q;
    logic           carry_q;
    logic           cout_q;
    logic           ovf_q;
    logic           ready_q;
    logic           done_q;

    logic [3:0]     nib_a_d;
    logic [3:0]     nib_b_d;
    logic           nib_cin_d;
    logic           last_d;

    // Slice inputs are only non-zero while a nibble is in flight
    always_comb begin
        nib_a_d   = 4'h0;
        nib_b_d   = 4'h0;
        nib_cin_d = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k_q == KW'(i)) begin
                    nib_a_d = a_q[4*i +: 4];
                    nib_b_d = b_q[4*i +: 4];
                end
            end
            nib_cin_d = carry_q;
        end
    end

    assign last_d = (k_q == KW'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b ^ {W{bus.sub}};
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        k_q     <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k_q == KW'(i)) begin
                            result_q[4*i +: 4] <= bus.add_s;
                        end
                    end
                    carry_q <= bus.add_cout;
                    if (last_d) begin
                        cout_q  <= bus.add_cout;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) &&
                                   (bus.add_s[3] != a_q[W-1]);
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.cout_o  = cout_q;
    assign bus.ovf     = ovf_q;
    assign bus.add_a   = nib_a_d;
    assign bus.add_b   = nib_b_d;
    assign bus.add_cin = nib_cin_d;
endmodule
